// File: rtl/cf_fft_1024_pkg.sv
// cf_fft_1024_pkg: shared constants, sample type, FSM states and bit reversal for the FFT unscrambler
package cf_fft_1024_pkg;
  localparam int N = 1024;
  localparam int LOG2N = 10;
  localparam int DW = 16;
  typedef logic [2*DW-1:0] cplx_t;
  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_READ} rstate_t;
  function automatic logic [LOG2N-1:0] bitrev10(input logic [LOG2N-1:0] a);
    return {<<{a}};
  endfunction
endpackage

// File: rtl/cf_fft_1024_unscramble_if.sv
// cf_fft_1024_unscramble_if: sample stream in, natural-order stream out; out_index only with CF_FFT_UNSCRAMBLE_INDEX_EN
interface cf_fft_1024_unscramble_if;
  import cf_fft_1024_pkg::*;
  logic ce;
  logic in_sync;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic out_sync;
  logic out_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic sync_err;
`ifdef CF_FFT_UNSCRAMBLE_INDEX_EN
  logic [LOG2N-1:0] out_index;
  modport master(output ce, in_sync, in_re, in_im, input out_sync, out_valid, out_re, out_im, sync_err, out_index);
  modport slave(input ce, in_sync, in_re, in_im, output out_sync, out_valid, out_re, out_im, sync_err, out_index);
`else
  modport master(output ce, in_sync, in_re, in_im, input out_sync, out_valid, out_re, out_im, sync_err);
  modport slave(input ce, in_sync, in_re, in_im, output out_sync, out_valid, out_re, out_im, sync_err);
`endif
endinterface

// File: rtl/cf_fft_1024_dpram.sv
// cf_fft_1024_dpram: 2048x32 simple dual-port RAM, bank bit in address MSB, ce-gated registered read
module cf_fft_1024_dpram
  import cf_fft_1024_pkg::*;
(
  input  logic           clock_c,
  input  logic           reset,
  input  logic           ce,
  input  logic           we,
  input  logic [LOG2N:0] waddr,
  input  cplx_t          wdata,
  input  logic           re,
  input  logic [LOG2N:0] raddr,
  output cplx_t          rdata
);
  cplx_t mem [2*N];
  always_ff @(posedge clock_c)
    if (ce && we) mem[waddr] <= wdata;
  always_ff @(posedge clock_c)
    if (reset) rdata <= '0;
    else if (ce && re) rdata <= mem[raddr];
endmodule

// File: rtl/cf_fft_1024_unscramble.sv
// cf_fft_1024_unscramble: ping-pong bit-reversed to natural order reorder; CF_FFT_UNSCRAMBLE_INDEX_EN adds out_index
module cf_fft_1024_unscramble
  import cf_fft_1024_pkg::*;
(
  input logic clock_c,
  input logic reset,
  cf_fft_1024_unscramble_if.slave bus
);
  wstate_t wst;
  rstate_t rst_st;
  logic [LOG2N-1:0] wcnt, rcnt;
  logic wb, rb;
  logic [1:0] full, set, clr, avail;
  logic early, done, rlast;
  assign early = wst == W_FILL && bus.in_sync && |wcnt;
  assign done = wst == W_FILL && !bus.in_sync && &wcnt;
  assign rlast = rst_st == R_READ && &rcnt;
  assign set = done ? (wb ? 2'b10 : 2'b01) : 2'b00;
  assign clr = rlast ? (rb ? 2'b10 : 2'b01) : 2'b00;
  // a bank finishing this cycle is readable immediately, giving gapless back-to-back frames
  assign avail = full | set;
  always_ff @(posedge clock_c)
    if (reset) begin
      wst <= W_IDLE;
      wcnt <= '0;
      wb <= 1'b0;
      bus.sync_err <= 1'b0;
    end else if (bus.ce) begin
      bus.sync_err <= early;
      if (bus.in_sync) begin
        wst <= W_FILL;
        wcnt <= 10'd1;
      end else if (wst == W_FILL) begin
        wcnt <= wcnt + 1'b1;
        if (&wcnt) begin
          wst <= W_IDLE;
          wb <= ~wb;
        end
      end
    end
  always_ff @(posedge clock_c)
    if (reset) begin
      rst_st <= R_IDLE;
      rcnt <= '0;
      rb <= 1'b0;
      full <= 2'b00;
      bus.out_valid <= 1'b0;
      bus.out_sync <= 1'b0;
`ifdef CF_FFT_UNSCRAMBLE_INDEX_EN
      bus.out_index <= '0;
`endif
    end else if (bus.ce) begin
      full <= (full | set) & ~clr;
      bus.out_valid <= rst_st == R_READ;
      bus.out_sync <= rst_st == R_READ && rcnt == '0;
`ifdef CF_FFT_UNSCRAMBLE_INDEX_EN
      bus.out_index <= rcnt;
`endif
      if (rst_st == R_IDLE) rst_st <= avail[rb] ? R_READ : R_IDLE;
      else begin
        rcnt <= rcnt + 1'b1;
        if (rlast) begin
          rb <= ~rb;
          rst_st <= avail[~rb] ? R_READ : R_IDLE;
        end
      end
    end
  cf_fft_1024_dpram ram (
    .clock_c(clock_c),
    .reset(reset),
    .ce(bus.ce),
    .we(bus.in_sync || wst == W_FILL),
    .waddr({wb, bus.in_sync ? '0 : bitrev10(wcnt)}),
    .wdata({bus.in_re, bus.in_im}),
    .re(rst_st == R_READ),
    .raddr({rb, rcnt}),
    .rdata({bus.out_re, bus.out_im})
  );
endmodule

// File: tb/tb_cf_fft_1024_unscramble.sv
// tb_cf_fft_1024_unscramble: random stream against a frame-level reorder model
module tb_cf_fft_1024_unscramble;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  cf_fft_1024_unscramble_if bus();
  cf_fft_1024_unscramble dut (.clock_c(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < 10; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // expected output per enabled-edge number, filled when a frame completes
  logic [15:0] e_re [int];
  logic [15:0] e_im [int];
  int e_bin [int];
  logic [15:0] fre [1024];
  logic [15:0] fim [1024];
  int ecnt = 0;
  int wpos = -1;
  logic s_rst, s_ce, s_sync, err, p_valid;
  logic [15:0] s_re, s_im, p_re;

  always @(posedge clk) begin
    s_rst = rst;
    s_ce = bus.ce;
    s_sync = bus.in_sync;
    s_re = bus.in_re;
    s_im = bus.in_im;
    #1;
    if (s_rst) begin
      e_re.delete();
      e_im.delete();
      e_bin.delete();
      wpos = -1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_sync", bus.out_sync, 0);
      chk("rst_re", bus.out_re, 0);
      chk("rst_im", bus.out_im, 0);
      chk("rst_err", bus.sync_err, 0);
`ifdef CF_FFT_UNSCRAMBLE_INDEX_EN
      chk("rst_index", bus.out_index, 0);
`endif
    end else if (!s_ce) begin
      chk("hold_valid", bus.out_valid, p_valid);
      chk("hold_re", bus.out_re, p_re);
    end else begin
      ecnt++;
      err = s_sync && wpos > 0;
      if (s_sync) wpos = 0;
      if (wpos >= 0) begin
        fre[wpos] = s_re;
        fim[wpos] = s_im;
        if (wpos == 1023) begin
          for (int j = 0; j < 1024; j++) begin
            e_re[ecnt + 1 + j] = fre[brev(j)];
            e_im[ecnt + 1 + j] = fim[brev(j)];
            e_bin[ecnt + 1 + j] = j;
          end
          wpos = -1;
        end else wpos++;
      end
      chk("sync_err", bus.sync_err, err);
      if (e_re.exists(ecnt)) begin
        chk("valid", bus.out_valid, 1);
        chk("out_sync", bus.out_sync, e_bin[ecnt] == 0);
        chk("out_re", bus.out_re, e_re[ecnt]);
        chk("out_im", bus.out_im, e_im[ecnt]);
`ifdef CF_FFT_UNSCRAMBLE_INDEX_EN
        chk("out_index", bus.out_index, e_bin[ecnt]);
`endif
        e_re.delete(ecnt);
        e_im.delete(ecnt);
        e_bin.delete(ecnt);
      end else begin
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_sync", bus.out_sync, 0);
      end
    end
    p_valid = bus.out_valid;
    p_re = bus.out_re;
  end

  task automatic drive(input logic c, input logic s, input logic [15:0] re, input logic [15:0] im);
    @(negedge clk);
    bus.ce = c;
    bus.in_sync = s;
    bus.in_re = re;
    bus.in_im = im;
  endtask

  task automatic send(input int n, input bit rce, input bit ramp);
    int k = 0;
    logic c;
    while (k < n) begin
      c = rce ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(c, k == 0 || (!c && $urandom_range(0, 3) == 0),
            ramp ? 16'(k) : 16'($urandom), ramp ? 16'(0 - k) : 16'($urandom));
      if (c) k++;
    end
  endtask

  task automatic idle(input int n, input bit rce);
    int k = 0;
    logic c;
    while (k < n) begin
      c = rce ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(c, 1'b0, 16'($urandom), 16'($urandom));
      if (c) k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.in_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.in_sync = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5, 0);
    send(1024, 0, 1);
    idle(1100, 0);
    repeat (3) send(1024, 0, 0);
    idle(1100, 0);
    send(1024, 1, 0);
    idle(1100, 1);
    send(500, 0, 0);
    send(1024, 0, 0);
    idle(1100, 0);
    send(1024, 0, 0);
    send(300, 0, 0);
    do_reset();
    idle(1500, 0);
    send(1024, 0, 0);
    idle(1100, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
